// File: rtl/dadda_mul_pipe.sv
// Purpose: WIDTH x WIDTH unsigned Dadda multiplier, pipelined as PP-matrix / Dadda-reduce / CPA.
// Latency: 3 cycles from input transfer to out_valid; 1 result per cycle when out_ready stays high.
// Backpressure: valid/ready; holds up to 3 results, in_ready drops only when all stages are full and C stalls.
// Optional macro APPROX_LSB_EN: the lowest APPROX_COLS product columns become a carry-free OR of
// their partial products; all higher columns are summed exactly from their own partial products.
module dadda_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int OUT_WIDTH   = 2*WIDTH,
  parameter int APPROX_COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 overflow,
  output logic [1:0]           in_flight
);

  // Product columns, per-column slot capacity, and length of the Dadda height table.
  localparam int NC   = 2*WIDTH;
  localparam int HMAX = WIDTH + 2;
  localparam int NSEQ = 8;

`ifdef APPROX_LSB_EN
  localparam int LOW_COLS = APPROX_COLS;
`else
  // Exact build: no column is approximated, whatever APPROX_COLS says.
  localparam int LOW_COLS = 0 * APPROX_COLS;
`endif

  typedef logic [WIDTH-1:0][WIDTH-1:0] ppmat_t;
  typedef logic [NC-1:0][HMAX-1:0]     colmat_t;

  // Reduces the partial-product matrix to two rows {row1,row0} with HA/FA cells.
  // Each pass targets the next lower Dadda height (2,3,4,6,9,13,...); a column is
  // compressed only as far as that target, using an HA when one bit too many remains.
  // Column heights depend only on WIDTH, so the loops describe a fixed network.
  function automatic logic [2*NC-1:0] dadda_reduce(input ppmat_t pp);
    colmat_t       cur;
    colmat_t       nxt;
    int            hc [NC];
    int            hn [NC];
    int            dseq [NSEQ];
    logic [NC-1:0] row0;
    logic [NC-1:0] row1;
    logic [NC-1:0] low_or;
    int            maxh;
    int            d;
    int            idx;
    int            rem;
    int            tot;
    logic          a;
    logic          b;
    logic          ci;
    cur    = '0;
    nxt    = '0;
    row0   = '0;
    row1   = '0;
    low_or = '0;
    for (int c = 0; c < NC; c++) begin
      hc[c] = 0;
      hn[c] = 0;
    end
    // Scatter pp[i][j] into column i+j; approximated columns collapse to an OR.
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j < LOW_COLS) begin
          low_or[i+j] = low_or[i+j] | pp[i][j];
        end else begin
          cur[i+j][hc[i+j]] = pp[i][j];
          hc[i+j] = hc[i+j] + 1;
        end
      end
    end
    dseq[0] = 2;
    for (int k = 1; k < NSEQ; k++) begin
      dseq[k] = (dseq[k-1] * 3) / 2;
    end
    for (int s = NSEQ - 1; s >= 0; s--) begin
      d    = dseq[s];
      maxh = 0;
      for (int c = 0; c < NC; c++) begin
        if (hc[c] > maxh) maxh = hc[c];
      end
      if (maxh > d) begin
        nxt = '0;
        for (int c = 0; c < NC; c++) hn[c] = 0;
        for (int c = 0; c < NC; c++) begin
          idx = 0;
          for (int it = 0; it < HMAX; it++) begin
            rem = hc[c] - idx;
            // Carries already landed in nxt[c] count towards this column's height.
            tot = rem + hn[c];
            if (tot > d && rem >= 2) begin
              a = cur[c][idx];
              b = cur[c][idx+1];
              if (tot == d + 1 || rem == 2) begin
                nxt[c][hn[c]] = a ^ b;
                hn[c] = hn[c] + 1;
                if (c + 1 < NC) begin
                  nxt[c+1][hn[c+1]] = a & b;
                  hn[c+1] = hn[c+1] + 1;
                end
                idx = idx + 2;
              end else begin
                ci = cur[c][idx+2];
                nxt[c][hn[c]] = a ^ b ^ ci;
                hn[c] = hn[c] + 1;
                if (c + 1 < NC) begin
                  nxt[c+1][hn[c+1]] = (a & b) | (a & ci) | (b & ci);
                  hn[c+1] = hn[c+1] + 1;
                end
                idx = idx + 3;
              end
            end
          end
          // Bits not consumed by a cell pass straight through.
          for (int k = 0; k < HMAX; k++) begin
            if (k >= idx && k < hc[c]) begin
              nxt[c][hn[c]] = cur[c][k];
              hn[c] = hn[c] + 1;
            end
          end
        end
        cur = nxt;
        for (int c = 0; c < NC; c++) hc[c] = hn[c];
      end
    end
    // Approximated columns hold no reduced bits, so the OR drops into row0 without overlap.
    for (int c = 0; c < NC; c++) begin
      row0[c] = cur[c][0] | low_or[c];
      row1[c] = cur[c][1];
    end
    return {row1, row0};
  endfunction

  logic          v_a, v_b, v_c;
  logic          adv_a, adv_b, adv_c;
  logic          in_fire, out_fire;
  ppmat_t        pp_a;
  logic [NC-1:0] row0_b, row1_b;
  logic [2*NC-1:0] reduced;
  logic [NC-1:0] sum_c;
  logic          ovf_next;

  // A stage moves when it is empty or its successor moves; C moves when empty or drained.
  assign adv_c     = !v_c || out_ready;
  assign adv_b     = !v_b || adv_c;
  assign adv_a     = !v_a || adv_b;
  assign in_ready  = adv_a;
  assign out_valid = v_c;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = v_c && out_ready;

  assign reduced = dadda_reduce(pp_a);
  assign sum_c   = row0_b + row1_b;

  if (OUT_WIDTH < NC) begin : g_ovf
    assign ovf_next = |sum_c[NC-1:OUT_WIDTH];
  end else begin : g_no_ovf
    assign ovf_next = 1'b0;
  end

  // Stage valid bits; reset drops every in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_a <= 1'b0;
      v_b <= 1'b0;
      v_c <= 1'b0;
    end else begin
      if (adv_a) v_a <= in_valid;
      if (adv_b) v_b <= v_a;
      if (adv_c) v_c <= v_b;
    end
  end

  // Stage A: capture the partial-product matrix pp[i][j] = in1[j] & in2[i].
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        pp_a[i] <= in1 & {WIDTH{in2[i]}};
      end
    end
  end

  // Stage B: capture the two reduced rows.
  always_ff @(posedge clk) begin
    if (adv_b && v_a) begin
      {row1_b, row0_b} <= reduced;
    end
  end

  // Stage C: final add, truncate, flag lost high bits; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out      <= '0;
      overflow <= 1'b0;
    end else if (adv_c && v_b) begin
      out      <= sum_c[OUT_WIDTH-1:0];
      overflow <= ovf_next;
    end
  end

  // Occupancy: +1 on accept, -1 on drain, unchanged when both happen together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight <= 2'd0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   in_flight <= in_flight + 2'd1;
        2'b01:   in_flight <= in_flight - 2'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
